// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   e_alu_op    - 4-bit operation code presented by the control unit.
//   e_alu_state - FSM state of alu_seq, also exported on its debug port.
//   needs_iter  - true for operations that go through the iterative core.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        NAND = 4'd5,
        NOR  = 4'd6,
        XNOR = 4'd7,
        SL   = 4'd8,
        SR   = 4'd9,
        ROR  = 4'd10,
        ROL  = 4'd11,
        MUL  = 4'd12,
        DIV  = 4'd13,
        MOD  = 4'd14
    } e_alu_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } e_alu_state;

    // Divide by zero bypasses the iterative core and finishes in one cycle.
    function automatic logic needs_iter(input e_alu_op op, input logic b_zero);
        return (op == MUL) || (((op == DIV) || (op == MOD)) && !b_zero);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control unit and alu_seq.
//   Request : in_valid, in_ready, op, srcA, srcB, cin, sign
//   Response: out_valid, out_ready, result, result_hi,
//             zero, cout, gt, equal, overflow, div0
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The sender holds its payload stable while valid is high and
// ready is low; ready never depends combinationally on valid.
// master = control unit side, slave = ALU side.
interface alu_seq_if #(parameter int WORD = 8);
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    e_alu_op           op;
    logic [WORD-1:0]   srcA;
    logic [WORD-1:0]   srcB;
    logic              cin;
    logic              sign;
    logic              out_valid;
    logic              out_ready;
    logic [WORD-1:0]   result;
    logic [WORD-1:0]   result_hi;
    logic              zero;
    logic              cout;
    logic              gt;
    logic              equal;
    logic              overflow;
    logic              div0;

    modport master (
        output in_valid, op, srcA, srcB, cin, sign, out_ready,
        input  in_ready, out_valid, result, result_hi,
               zero, cout, gt, equal, overflow, div0
    );

    modport slave (
        input  in_valid, op, srcA, srcB, cin, sign, out_ready,
        output in_ready, out_valid, result, result_hi,
               zero, cout, gt, equal, overflow, div0
    );

endinterface

// File: rtl/alu_iter_core.sv
// alu_iter_core: shared shift-add multiplier / restoring divider.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands (one cycle pulse)
//   is_div     : 1 = divide, 0 = multiply
//   sign       : operands are two's complement
//   a, b       : operands (multiplicand/multiplier or dividend/divisor)
//   busy       : iterations still outstanding
//   lo, hi     : MUL -> {hi,lo} product; DIV -> lo quotient, hi remainder
// Works on magnitudes and applies the sign correction on the outputs.
module alu_iter_core #(parameter int WORD = 8) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic            sign,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic            busy,
    output logic [WORD-1:0] lo,
    output logic [WORD-1:0] hi
);
    localparam int WSIZE = $clog2(WORD);

    logic [WSIZE:0]      cnt;
    logic [WORD-1:0]     acc;
    logic [WORD-1:0]     q;
    logic [WORD-1:0]     bm;
    logic                div_r;
    logic                neg_x;
    logic                neg_a;
    logic [WORD-1:0]     a_mag;
    logic [WORD-1:0]     b_mag;
    logic [2*WORD-1:0]   first;
    logic [2*WORD-1:0]   prod_n;

    // One iteration on {acc,q}. Divide: shift in the next dividend bit and
    // keep the trial difference if it did not go negative. Multiply: add
    // the multiplicand when the current multiplier bit is set, shift right.
    function automatic logic [2*WORD-1:0] step(input logic d,
                                               input logic [WORD-1:0] acc_i,
                                               input logic [WORD-1:0] q_i,
                                               input logic [WORD-1:0] bm_i);
        logic [WORD:0] t;
        if (d) begin
            t = {acc_i, q_i[WORD-1]} - {1'b0, bm_i};
            if (!t[WORD]) step = {t[WORD-1:0], q_i[WORD-2:0], 1'b1};
            else          step = {acc_i[WORD-2:0], q_i[WORD-1], q_i[WORD-2:0], 1'b0};
        end else begin
            t = q_i[0] ? ({1'b0, acc_i} + {1'b0, bm_i}) : {1'b0, acc_i};
            step = {t, q_i[WORD-1:1]};
        end
    endfunction

    assign a_mag = (sign && a[WORD-1]) ? -a : a;
    assign b_mag = (sign && b[WORD-1]) ? -b : b;

    // The first iteration is folded into the load cycle, so together with
    // the WORD-1 counted iterations the owning FSM spends WORD cycles in CALC.
    assign first = step(is_div, '0, a_mag, b_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            bm    <= '0;
            div_r <= 1'b0;
            neg_x <= 1'b0;
            neg_a <= 1'b0;
        end else if (start) begin
            {acc, q} <= first;
            bm       <= b_mag;
            div_r    <= is_div;
            neg_x    <= sign && (a[WORD-1] ^ b[WORD-1]);
            neg_a    <= sign && a[WORD-1];
            cnt      <= (WSIZE+1)'(WORD-1);
        end else if (cnt != '0) begin
            {acc, q} <= step(div_r, acc, q, bm);
            cnt      <= cnt - (WSIZE+1)'(1);
        end
    end

    assign busy   = (cnt != '0);
    assign prod_n = neg_x ? -{acc, q} : {acc, q};
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign lo = div_r ? (neg_x ? -q : q) : prod_n[WORD-1:0];
    assign hi = div_r ? (neg_a ? -acc : acc) : prod_n[2*WORD-1:WORD];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU between register-file read and writeback.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_if slave (request/response handshake, operands,
//                registered result/result_hi and flags)
//   dbg_state  : current FSM state
// Single-cycle ops finish IDLE -> DONE; MUL and DIV/MOD with non-zero
// divisor go IDLE -> CALC (WORD cycles) -> DONE. DONE holds outputs until
// out_ready.
module alu_seq
    import alu_pkg::*;
#(parameter int WORD = 8) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus,
    output e_alu_state  dbg_state
);
    localparam int WSIZE = $clog2(WORD);

    e_alu_state        state;
    e_alu_op           op_r;
    logic [WORD-1:0]   a_r;
    logic [WORD-1:0]   b_r;
    logic              sign_r;
    logic              accept;
    logic              core_start;
    logic              core_busy;
    logic [WORD-1:0]   core_lo;
    logic [WORD-1:0]   core_hi;

    assign bus.in_ready = (state == IDLE);
    assign dbg_state    = state;
    assign accept       = bus.in_valid && bus.in_ready;
    assign core_start   = accept && needs_iter(bus.op, bus.srcB == '0);

    alu_iter_core #(.WORD(WORD)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (core_start),
        .is_div (bus.op != MUL),
        .sign   (bus.sign),
        .a      (bus.srcA),
        .b      (bus.srcB),
        .busy   (core_busy),
        .lo     (core_lo),
        .hi     (core_hi)
    );

    // Single-cycle datapath, evaluated on the request inputs.
    logic [WSIZE-1:0]   shmt;
    logic [WORD:0]      add_w;
    logic [WORD:0]      sub_w;
    logic [WORD+1:0]    add_s;
    logic [WORD+1:0]    sub_s;
    logic [2*WORD-1:0]  rol_w;
    logic [2*WORD-1:0]  ror_w;
    logic [WORD-1:0]    sra;
    logic [WORD-1:0]    sc_result;
    logic [WORD-1:0]    sc_hi;
    logic               sc_cout;
    logic               sc_ovf;
    logic               sc_div0;
    logic               gt_in;
    logic               gt_r;

    assign shmt  = bus.srcB[WSIZE-1:0];
    assign add_w = {1'b0, bus.srcA} + (WORD+1)'(bus.cin) + {1'b0, bus.srcB};
    assign sub_w = {1'b0, bus.srcA} + (WORD+1)'(bus.cin) - {1'b0, bus.srcB};
    // Two guard bits: the signed result fits iff the top three bits agree.
    assign add_s = {{2{bus.srcA[WORD-1]}}, bus.srcA} + (WORD+2)'(bus.cin)
                 + {{2{bus.srcB[WORD-1]}}, bus.srcB};
    assign sub_s = {{2{bus.srcA[WORD-1]}}, bus.srcA} + (WORD+2)'(bus.cin)
                 - {{2{bus.srcB[WORD-1]}}, bus.srcB};
    // Rotates via a doubled word so any shift amount wraps naturally.
    assign rol_w = {bus.srcA, bus.srcA} << shmt;
    assign ror_w = {bus.srcA, bus.srcA} >> shmt;
    assign sra   = $signed(bus.srcA) >>> shmt;

    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_cout   = 1'b0;
        sc_ovf    = 1'b0;
        sc_div0   = 1'b0;
        case (bus.op)
            ADD: begin
                {sc_cout, sc_result} = add_w;
                sc_ovf = (add_s[WORD+1] != add_s[WORD]) || (add_s[WORD] != add_s[WORD-1]);
            end
            SUB: begin
                {sc_cout, sc_result} = sub_w;
                sc_ovf = (sub_s[WORD+1] != sub_s[WORD]) || (sub_s[WORD] != sub_s[WORD-1]);
            end
            AND:  sc_result = bus.srcA & bus.srcB;
            OR:   sc_result = bus.srcA | bus.srcB;
            XOR:  sc_result = bus.srcA ^ bus.srcB;
            NAND: sc_result = ~(bus.srcA & bus.srcB);
            NOR:  sc_result = ~(bus.srcA | bus.srcB);
            XNOR: sc_result = ~(bus.srcA ^ bus.srcB);
            SL:   sc_result = bus.srcA << shmt;
            SR:   sc_result = bus.sign ? sra : (bus.srcA >> shmt);
            ROL:  sc_result = rol_w[2*WORD-1:WORD];
            ROR:  sc_result = ror_w[WORD-1:0];
            // Only reached with a zero divisor; other divides use the core.
            DIV, MOD: begin
                sc_result = '1;
                sc_hi     = bus.srcA;
                sc_div0   = 1'b1;
            end
            default: ;
        endcase
    end

    assign gt_in = bus.sign ? ($signed(bus.srcA) > $signed(bus.srcB)) : (bus.srcA > bus.srcB);
    assign gt_r  = sign_r ? ($signed(a_r) > $signed(b_r)) : (a_r > b_r);

    // Iterative-op results and flags, taken when the core finishes.
    logic [WORD-1:0] iter_res;
    logic            mul_ovf;
    logic            div_ovf;

    assign iter_res = (op_r == MOD) ? core_hi : core_lo;
    assign mul_ovf  = sign_r ? (core_hi != {WORD{core_lo[WORD-1]}}) : (core_hi != '0);
    assign div_ovf  = (op_r == DIV) && sign_r && (a_r == {1'b1, {(WORD-1){1'b0}}}) && (b_r == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_r          <= ADD;
            a_r           <= '0;
            b_r           <= '0;
            sign_r        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.zero      <= 1'b0;
            bus.cout      <= 1'b0;
            bus.gt        <= 1'b0;
            bus.equal     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r   <= bus.op;
                        a_r    <= bus.srcA;
                        b_r    <= bus.srcB;
                        sign_r <= bus.sign;
                        if (core_start) begin
                            state <= CALC;
                        end else begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.result    <= sc_result;
                            bus.result_hi <= sc_hi;
                            bus.zero      <= (sc_result == '0);
                            bus.cout      <= sc_cout;
                            bus.gt        <= gt_in;
                            bus.equal     <= (bus.srcA == bus.srcB);
                            bus.overflow  <= sc_ovf;
                            bus.div0      <= sc_div0;
                        end
                    end
                end
                CALC: begin
                    if (!core_busy) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= iter_res;
                        bus.result_hi <= core_hi;
                        bus.zero      <= (iter_res == '0);
                        bus.cout      <= 1'b0;
                        bus.gt        <= gt_r;
                        bus.equal     <= (a_r == b_r);
                        bus.overflow  <= (op_r == MUL) ? mul_ovf : div_ovf;
                        bus.div0      <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq (WORD = 8). Stimulus pushes the
// hand-computed response into exp_q; a negedge monitor compares whatever the
// DUT presents while out_valid is high and pops on the handshake.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0]  res;
        logic [7:0]  hi;
        logic [5:0]  flags;    // {zero, cout, gt, equal, overflow, div0}
        logic [7:0]  lat;
        logic [31:0] acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    e_alu_state  dbg_state;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        seen = 1'b0;
    exp_t        exp_q[$];

    alu_seq_if #(.WORD(8)) bus();

    alu_seq #(.WORD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [5:0] flags_now();
        return {bus.zero, bus.cout, bus.gt, bus.equal, bus.overflow, bus.div0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input e_alu_op o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s,
                        input logic [7:0] er, input logic [7:0] eh,
                        input logic [5:0] ef, input logic [7:0] el);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.op = o;
        bus.srcA = a;
        bus.srcB = b;
        bus.cin = c;
        bus.sign = s;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 for op %s", o.name());
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        e.res = er;
        e.hi = eh;
        e.flags = ef;
        e.lat = el;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got result %0h with empty expected queue", bus.result);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - exp_q[0].acc_cyc + 1, exp_q[0].lat);
                    seen = 1'b1;
                end
                chk("result", bus.result, exp_q[0].res);
                chk("result_hi", bus.result_hi, exp_q[0].hi);
                chk("flags", flags_now(), exp_q[0].flags);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = ADD;
        bus.srcA = '0;
        bus.srcB = '0;
        bus.cin = 1'b0;
        bus.sign = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_result", {bus.result, bus.result_hi}, 0);
        chk("rst_flags", flags_now(), 0);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;

        // add/sub and logic
        send(ADD, 8'd120, 8'd100, 1'b0, 1'b0, 8'hDC, 8'h00, 6'b001010, 1);
        send(ADD, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 6'b111000, 1);
        send(SUB, 8'd5, 8'd7, 1'b0, 1'b0, 8'hFE, 8'h00, 6'b010000, 1);
        send(XOR, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h00, 6'b100100, 1);
        send(AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00, 6'b001000, 1);
        // shifts and rotates
        send(SL, 8'h81, 8'd3, 1'b0, 1'b0, 8'h08, 8'h00, 6'b001000, 1);
        send(ROL, 8'hC0, 8'd1, 1'b0, 1'b0, 8'h81, 8'h00, 6'b001000, 1);
        send(ROR, 8'h03, 8'd1, 1'b0, 1'b0, 8'h81, 8'h00, 6'b001000, 1);
        send(SR, 8'h84, 8'd2, 1'b0, 1'b1, 8'hE1, 8'h00, 6'b000000, 1);
        // multiply
        send(MUL, 8'd200, 8'd3, 1'b0, 1'b0, 8'h58, 8'h02, 6'b001010, 9);
        send(MUL, 8'hFB, 8'h08, 1'b0, 1'b1, 8'hD8, 8'hFF, 6'b000000, 9);
        // divide / modulo
        send(DIV, 8'hBF, 8'h04, 1'b0, 1'b1, 8'hF0, 8'hFF, 6'b000000, 9);
        send(DIV, 8'h07, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h07, 6'b001001, 1);
        send(DIV, 8'h80, 8'hFF, 1'b0, 1'b1, 8'h80, 8'h00, 6'b000010, 9);
        send(MOD, 8'hF9, 8'h02, 1'b0, 1'b1, 8'hFF, 8'hFF, 6'b000000, 9);
        send(DIV, 8'd200, 8'd7, 1'b0, 1'b0, 8'h1C, 8'h04, 6'b001000, 9);
        drain();

        // back-pressure: hold out_ready low with in_valid toggling
        bus.out_ready = 1'b0;
        send(MUL, 8'd15, 8'd17, 1'b0, 1'b0, 8'hFF, 8'h00, 6'b000000, 9);
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("stall_reached_done", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.op = ADD;
            bus.srcA = 8'($urandom_range(0, 255));
            bus.srcB = 8'($urandom_range(0, 255));
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_state", dbg_state, DONE);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("handshake_cycle_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("after_handshake_in_ready", bus.in_ready, 1);
        chk("after_handshake_state", dbg_state, IDLE);
        send(AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00, 6'b001000, 1);
        drain();

        // reset during CALC cycle 4 of a divide
        send(DIV, 8'd100, 8'd3, 1'b0, 1'b0, 8'h21, 8'h01, 6'b001000, 9);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_result", {bus.result, bus.result_hi}, 0);
        chk("midreset_flags", flags_now(), 0);
        chk("midreset_in_ready", bus.in_ready, 1);
        chk("midreset_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("postreset_out_valid", bus.out_valid, 0);
        end
        send(SUB, 8'hF6, 8'hEC, 1'b0, 1'b1, 8'h0A, 8'h00, 6'b001000, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
